parcnn_top: RTL and testbench



---
 rtl/parcnn_top.sv | 125 ++++++++++++
 tb/tb_parcnn_top.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/parcnn_top.sv
`default_nettype none
// ============================================================================
// Module   : parcnn_top
// Brief    : Streaming 3x3 two-feature convolution with ReLU and saturation.
// Revision : 1.0
// ============================================================================
module parcnn_top #(
    parameter int          SCREEN_WIDTH  = 36,
    parameter int          SCREEN_HEIGHT = 36,
    parameter logic [80:0] KERNEL1       = {9{9'h020}},
    parameter logic [80:0] KERNEL2       = {36'h0, 9'h080, 36'h0}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        screen_x_pos,
    input  logic [5:0]        screen_y_pos,
    input  logic signed [8:0] test_pixel,
    output logic [8:0]        rect1,
    output logic [8:0]        rect2
);

    localparam int         c_LB_DEPTH = 2 * SCREEN_WIDTH + 3;
    localparam logic [6:0] c_X_LIMIT  = 7'(SCREEN_WIDTH);
    localparam logic [6:0] c_Y_LIMIT  = 7'(SCREEN_HEIGHT);

    logic signed [8:0]  r_line [c_LB_DEPTH];
    logic signed [8:0]  w_tap [9];
    logic signed [17:0] w_prod1 [9];
    logic signed [17:0] w_prod2 [9];
    logic signed [17:0] r_prod1 [9];
    logic signed [17:0] r_prod2 [9];
    logic signed [21:0] w_sum1;
    logic signed [21:0] w_sum2;
    logic signed [21:0] r_sum1;
    logic signed [21:0] r_sum2;
    logic               w_win_ok;
    logic               r_valid_win;
    logic               r_valid_prod;
    logic               r_valid_sum;

    // The sampled pixel is the bottom-right corner; both upper rows must fit on screen.
    assign w_win_ok = (screen_x_pos >= 6'd2) && (screen_y_pos >= 6'd2)
                   && ({1'b0, screen_x_pos} < c_X_LIMIT)
                   && ({1'b0, screen_y_pos} < c_Y_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_LB_DEPTH; i++) begin
                r_line[i] <= '0;
            end
            r_valid_win <= 1'b0;
        end else begin
            r_line[0] <= test_pixel;
            for (int i = 1; i < c_LB_DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
            r_valid_win <= w_win_ok;
        end
    end

    // Tap k = 3*row + col; row 0 is the oldest line, col 0 the oldest column.
    generate
        for (genvar k = 0; k < 9; k++) begin : g_tap
            localparam int                c_ROW = k / 3;
            localparam int                c_COL = k % 3;
            localparam logic signed [8:0] c_K1  = KERNEL1[9*k +: 9];
            localparam logic signed [8:0] c_K2  = KERNEL2[9*k +: 9];

            assign w_tap[k]   = r_line[(2 - c_ROW) * SCREEN_WIDTH + (2 - c_COL)];
            assign w_prod1[k] = 18'(w_tap[k]) * 18'(c_K1);
            assign w_prod2[k] = 18'(w_tap[k]) * 18'(c_K2);
        end
    endgenerate

    always_comb begin
        w_sum1 = '0;
        w_sum2 = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum1 = w_sum1 + 22'(r_prod1[k]);
            w_sum2 = w_sum2 + 22'(r_prod2[k]);
        end
    end

    function automatic logic [8:0] relu_sat(input logic signed [21:0] sum);
        logic signed [21:0] shifted;
        shifted = sum >>> 8;
        if (shifted[21]) begin
            return 9'h000;
        end else if (shifted > 22'sd255) begin
            return 9'h0FF;
        end
        return shifted[8:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                r_prod1[k] <= '0;
                r_prod2[k] <= '0;
            end
            r_sum1       <= '0;
            r_sum2       <= '0;
            r_valid_prod <= 1'b0;
            r_valid_sum  <= 1'b0;
            rect1        <= '0;
            rect2        <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                r_prod1[k] <= w_prod1[k];
                r_prod2[k] <= w_prod2[k];
            end
            r_valid_prod <= r_valid_win;
            r_sum1       <= w_sum1;
            r_sum2       <= w_sum2;
            r_valid_sum  <= r_valid_prod;
            // Invalid windows leave the outputs holding the last valid result.
            if (r_valid_sum) begin
                rect1 <= relu_sat(r_sum1);
                rect2 <= relu_sat(r_sum2);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parcnn_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_parcnn_top
// Brief    : Scoreboard bench for parcnn_top, default and alternate kernels.
// Revision : 1.0
// ============================================================================
module tb_parcnn_top;

    localparam int          W      = 36;
    localparam int          H      = 36;
    localparam logic [80:0] K1_DEF = {9{9'h020}};
    localparam logic [80:0] K2_DEF = {36'h0, 9'h080, 36'h0};
    localparam logic [80:0] K1_ALT = {9{9'h0FF}};
    localparam logic [80:0] K2_ALT = {36'h0, 9'h1FF, 36'h0};

    logic       clock        = 1'b0;
    logic       reset        = 1'b1;
    logic [5:0] screen_x_pos = '0;
    logic [5:0] screen_y_pos = '0;
    logic [8:0] test_pixel   = '0;
    logic [8:0] rect1_a, rect2_a, rect1_b, rect2_b;

    typedef struct {
        int         due;
        logic [8:0] a1;
        logic [8:0] a2;
        logic [8:0] b1;
        logic [8:0] b2;
    } exp_t;

    exp_t              sb[$];
    exp_t              hold;
    logic signed [8:0] img [H][W];
    int                edge_cnt = 0;
    int                checks   = 0;
    int                failures = 0;

    parcnn_top dut (
        .clock(clock), .reset(reset),
        .screen_x_pos(screen_x_pos), .screen_y_pos(screen_y_pos),
        .test_pixel(test_pixel), .rect1(rect1_a), .rect2(rect2_a)
    );

    parcnn_top #(.KERNEL1(K1_ALT), .KERNEL2(K2_ALT)) dut_alt (
        .clock(clock), .reset(reset),
        .screen_x_pos(screen_x_pos), .screen_y_pos(screen_y_pos),
        .test_pixel(test_pixel), .rect1(rect1_b), .rect2(rect2_b)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference: dot product over the current frame image, floor-divided by 256.
    function automatic logic [8:0] ref_feature(input logic [80:0] kern, input int x, input int y);
        int acc;
        acc = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                logic signed [8:0] coef;
                coef = kern[9*(3*r+c) +: 9];
                acc += int'(img[y-2+r][x-2+c]) * int'(coef);
            end
        end
        if (acc < 0) return 9'd0;
        if (acc / 256 > 255) return 9'd255;
        return 9'(acc / 256);
    endfunction

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = '0;
    endtask

    task automatic step(input int x, input int y, input logic [8:0] p);
        exp_t e;
        screen_x_pos = 6'(x);
        screen_y_pos = 6'(y);
        test_pixel   = p;
        @(posedge clock);
        #1;
        if (!reset) begin
            img[y][x] = p;
            if (x >= 2 && y >= 2) begin
                e.due = edge_cnt + 3;
                e.a1  = ref_feature(K1_DEF, x, y);
                e.a2  = ref_feature(K2_DEF, x, y);
                e.b1  = ref_feature(K1_ALT, x, y);
                e.b2  = ref_feature(K2_ALT, x, y);
                sb.push_back(e);
            end
        end
    endtask

    // Mid-cycle reset assertion while the clock is high, held a few edges.
    task automatic async_abort();
        #2;
        reset = 1'b1;
        sb.delete();
        clear_img();
        for (int i = 0; i < 3; i++) step(i, 0, 9'($urandom_range(0, 511)));
        reset = 1'b0;
    endtask

    // mode 0: constant, 1: zero border, 2: single pixel at (10,10), else random.
    task automatic run_frame(input int mode, input logic [8:0] val, input int abort_y);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                logic [8:0] p;
                case (mode)
                    0:       p = val;
                    1:       p = (x < 2 || y < 2) ? 9'h000 : val;
                    2:       p = (x == 10 && y == 10) ? val : 9'h000;
                    default: p = 9'($urandom_range(0, 511));
                endcase
                step(x, y, p);
                if (y == abort_y && x == 5) begin
                    async_abort();
                    return;
                end
            end
        end
    endtask

    initial begin
        exp_t junk;
        hold = '{0, 9'd0, 9'd0, 9'd0, 9'd0};
        #1;
        forever begin
            @(negedge clock or posedge reset);
            if (clock === 1'b1) begin
                #1;
                checks++;
                if (rect1_a !== 9'd0 || rect2_a !== 9'd0 || rect1_b !== 9'd0 || rect2_b !== 9'd0) begin
                    failures++;
                    $display("FAIL async_reset: got %h %h %h %h, want all 000",
                             rect1_a, rect2_a, rect1_b, rect2_b);
                end
            end else begin
                if (reset) hold = '{0, 9'd0, 9'd0, 9'd0, 9'd0};
                while (sb.size() > 0 && sb[0].due < edge_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL stale_entry: expected result due at edge %0d never consumed (now %0d)",
                             sb[0].due, edge_cnt);
                    junk = sb.pop_front();
                end
                if (sb.size() > 0 && sb[0].due == edge_cnt) hold = sb.pop_front();
                checks++;
                if (rect1_a !== hold.a1 || rect2_a !== hold.a2 ||
                    rect1_b !== hold.b1 || rect2_b !== hold.b2) begin
                    failures++;
                    $display("FAIL rect edge %0d: got def %h/%h alt %h/%h, want def %h/%h alt %h/%h",
                             edge_cnt, rect1_a, rect2_a, rect1_b, rect2_b,
                             hold.a1, hold.a2, hold.b1, hold.b2);
                end
            end
        end
    end

    initial begin
        clear_img();
        for (int i = 0; i < 10; i++) step(i, 0, 9'($urandom_range(0, 511)));
        reset = 1'b0;
        run_frame(0, 9'h040, -1);
        run_frame(1, 9'h040, -1);
        run_frame(0, 9'h1C0, -1);
        run_frame(0, 9'h0FF, -1);
        run_frame(2, 9'h100, -1);
        run_frame(2, 9'h0FF, -1);
        run_frame(2, 9'h080, -1);
        run_frame(3, 9'h000, -1);
        run_frame(0, 9'h040, 20);
        run_frame(3, 9'h000, -1);
        for (int i = 0; i < 5; i++) step(0, 0, 9'h000);
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
